// File: rtl/xreg_wb_arbiter.sv
// rtl/xreg_wb_arbiter.sv - round-robin writeback arbiter for the x register file
// Adds a pending-load scoreboard so that non-load writes cannot overtake an outstanding load.
module xreg_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [2:0]        req_valid,
  input  logic [11:0]       req_index,
  input  logic [3*XLEN-1:0] req_data,
  output logic [2:0]        req_ready,
  input  logic              rsv_valid,
  input  logic [3:0]        rsv_index,
  output logic              rsv_ready,
  input  logic              flush,
  output logic [15:0]       busy,
  output logic              wreq,
  output logic [3:0]        windex,
  output logic [XLEN-1:0]   wdata
);

  logic [1:0]      last;
  logic [1:0]      gnum;
  logic [2:0]      elig;
  logic [2:0]      grant;
  logic            xfer;
  logic [3:0]      idx [3];
  logic [XLEN-1:0] dat [3];
  logic [3:0]      sel_idx;
  logic [XLEN-1:0] sel_data;
  logic [15:0]     busy_next;

  // Load returns (port 0) are never blocked: they are what clears the scoreboard.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      idx[i] = req_index[4*i +: 4];
      dat[i] = req_data[XLEN*i +: XLEN];
    end
    elig[0] = req_valid[0];
    elig[1] = req_valid[1] && ((idx[1] == 4'd0) || !busy[idx[1]]);
    elig[2] = req_valid[2] && ((idx[2] == 4'd0) || !busy[idx[2]]);
  end

  always_comb begin
    grant = 3'b000;
    case (last)
      2'd0: begin
        if (elig[1])      grant = 3'b010;
        else if (elig[2]) grant = 3'b100;
        else if (elig[0]) grant = 3'b001;
      end
      2'd1: begin
        if (elig[2])      grant = 3'b100;
        else if (elig[0]) grant = 3'b001;
        else if (elig[1]) grant = 3'b010;
      end
      default: begin
        if (elig[0])      grant = 3'b001;
        else if (elig[1]) grant = 3'b010;
        else if (elig[2]) grant = 3'b100;
      end
    endcase
  end

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    gnum     = 2'd0;
    sel_idx  = idx[0];
    sel_data = dat[0];
    if (grant[1]) begin
      gnum     = 2'd1;
      sel_idx  = idx[1];
      sel_data = dat[1];
    end else if (grant[2]) begin
      gnum     = 2'd2;
      sel_idx  = idx[2];
      sel_data = dat[2];
    end
  end

  assign rsv_ready = rsv_valid && !flush && ((rsv_index == 4'd0) || !busy[rsv_index]);

  // A reserve landing on the same edge as an unrelated load clear both take effect.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (grant[0]) busy_next[idx[0]] = 1'b0;
      if (rsv_ready && (rsv_index != 4'd0)) busy_next[rsv_index] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last   <= 2'd2;
      wreq   <= 1'b0;
      windex <= '0;
      wdata  <= '0;
      busy   <= '0;
    end else begin
      wreq <= xfer && (sel_idx != 4'd0);
      if (xfer) begin
        windex <= sel_idx;
        wdata  <= sel_data;
        last   <= gnum;
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_xreg_wb_arbiter.sv
// tb/tb_xreg_wb_arbiter.sv - directed and randomized bench for xreg_wb_arbiter
module tb_xreg_wb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [2:0]  rv;
  logic [3:0]  ri [3];
  logic [31:0] rd [3];
  logic        rsvv;
  logic [3:0]  rsvi;
  logic        fl;

  logic [11:0] req_index;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rsv_ready;
  logic [15:0] busy;
  logic        wreq;
  logic [3:0]  windex;
  logic [31:0] wdata;

  assign req_index = {ri[2], ri[1], ri[0]};
  assign req_data  = {rd[2], rd[1], rd[0]};

  xreg_wb_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(rv), .req_index(req_index), .req_data(req_data), .req_ready(req_ready),
    .rsv_valid(rsvv), .rsv_index(rsvi), .rsv_ready(rsv_ready),
    .flush(fl), .busy(busy),
    .wreq(wreq), .windex(windex), .wdata(wdata)
  );

  logic [15:0] m_busy;
  int          m_last;
  logic        m_wreq;
  logic [3:0]  m_windex;
  logic [31:0] m_wdata;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  logic [2:0] obs_ready;
  logic       obs_rsv;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", name, obs, exp, $time);
      $error("check %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic bit eligible(int p);
    if (!rv[p]) return 1'b0;
    if (p == 0) return 1'b1;
    return (ri[p] == 4'd0) || (m_busy[ri[p]] == 1'b0);
  endfunction

  function automatic logic [2:0] model_grant();
    for (int k = 1; k <= 3; k++) begin
      int p;
      p = (m_last + k) % 3;
      if (eligible(p)) return 3'(1 << p);
    end
    return 3'b000;
  endfunction

  function automatic logic model_rsv();
    return rsvv && !fl && ((rsvi == 4'd0) || !m_busy[rsvi]);
  endfunction

  task automatic model_reset();
    m_busy = '0; m_last = 2; m_wreq = 0; m_windex = '0; m_wdata = '0;
  endtask

  task automatic model_step(input logic [2:0] g, input logic r);
    int p;
    p = g[1] ? 1 : (g[2] ? 2 : 0);
    m_wreq = 1'b0;
    if (g != 3'b000) begin
      m_wreq   = (ri[p] != 4'd0);
      m_windex = ri[p];
      m_wdata  = rd[p];
      m_last   = p;
    end
    if (fl) begin
      m_busy = '0;
    end else begin
      if (g[0]) m_busy[ri[0]] = 1'b0;
      if (r && rsvi != 4'd0) m_busy[rsvi] = 1'b1;
    end
  endtask

  // Inputs are driven just after a rising edge; combinational grants are sampled mid-cycle.
  task automatic cycle();
    logic [2:0] g;
    logic       r;
    #2;
    g = model_grant();
    r = model_rsv();
    obs_ready = req_ready;
    obs_rsv   = rsv_ready;
    chk("req_ready", req_ready, g);
    chk("rsv_ready", rsv_ready, r);
    @(posedge clk);
    #1;
    model_step(g, r);
    chk("wreq", wreq, m_wreq);
    chk("windex", windex, m_windex);
    chk("wdata", wdata, m_wdata);
    chk("busy", busy, m_busy);
  endtask

  initial begin
    rstn = 1'b0; rv = '0; rsvv = 1'b0; rsvi = '0; fl = 1'b0;
    for (int p = 0; p < 3; p++) begin ri[p] = '0; rd[p] = '0; end
    model_reset();
    #3;
    chk("rst_wreq", wreq, 0);
    chk("rst_windex", windex, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    rv = 3'b111; ri[0] = 5; ri[1] = 6; ri[2] = 7;
    rd[0] = 32'hA0; rd[1] = 32'hA1; rd[2] = 32'hA2;
    cycle(); chk("rr_g0", obs_ready, 3'b001); chk("rr_w0", windex, 5);
    rv = 3'b110;
    cycle(); chk("rr_g1", obs_ready, 3'b010); chk("rr_w1", windex, 6);
    rv = 3'b100;
    cycle(); chk("rr_g2", obs_ready, 3'b100); chk("rr_w2", windex, 7); chk("rr_d2", wdata, 32'hA2);

    rv = 3'b000; rsvv = 1'b1; rsvi = 9;
    cycle(); chk("rsv9_busy", busy, 16'h0200);
    rsvv = 1'b0; rv = 3'b010; ri[1] = 9; rd[1] = 32'h1111_1111;
    cycle(); chk("blk_p1", obs_ready, 3'b000);
    rv = 3'b011; ri[0] = 9; rd[0] = 32'hDEAD_BEEF;
    cycle(); chk("ld_g", obs_ready, 3'b001); chk("ld_wreq", wreq, 1);
    chk("ld_widx", windex, 9); chk("ld_wdata", wdata, 32'hDEAD_BEEF); chk("ld_busy", busy, 0);
    rv = 3'b010;
    cycle(); chk("unblk_p1", obs_ready, 3'b010); chk("unblk_d", wdata, 32'h1111_1111);

    rv = 3'b100; ri[2] = 0; rd[2] = 32'h1234;
    cycle(); chk("x0_ready", obs_ready, 3'b100); chk("x0_wreq", wreq, 0);
    rv = 3'b000; rsvv = 1'b1; rsvi = 0;
    cycle(); chk("rsv0_ready", obs_rsv, 1); chk("rsv0_busy", busy, 0);

    rsvi = 3;
    cycle(); chk("rsv3_busy", busy, 16'h0008);
    rv = 3'b001; ri[0] = 3;
    cycle(); chk("same_rsv", obs_rsv, 0); chk("same_busy", busy, 0);
    rv = 3'b000;
    cycle();
    rv = 3'b001; ri[0] = 3; rsvi = 4;
    cycle(); chk("diff_busy", busy, 16'h0010);

    rv = 3'b000; rsvi = 5; cycle();
    rsvi = 6; cycle();
    rsvi = 7; cycle(); chk("f0_busy", busy, 16'h00F0);
    fl = 1'b1; rv = 3'b010; ri[1] = 2; rd[1] = 32'hCAFE; rsvi = 8;
    cycle(); chk("fl_rsv", obs_rsv, 0); chk("fl_busy", busy, 0);
    chk("fl_wreq", wreq, 1); chk("fl_widx", windex, 2);
    fl = 1'b0;

    rv = 3'b001; ri[0] = 10; rd[0] = 32'h5555; rsvi = 11;
    cycle(); chk("pre_wreq", wreq, 1); chk("pre_busy", busy, 16'h0800);
    rv = 3'b000; rsvv = 1'b0; rstn = 1'b0;
    #1;
    chk("ar_wreq", wreq, 0); chk("ar_windex", windex, 0);
    chk("ar_wdata", wdata, 0); chk("ar_busy", busy, 0);
    model_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    rv = 3'b111; ri[0] = 1; ri[1] = 2; ri[2] = 3;
    cycle(); chk("ar_first", obs_ready, 3'b001);

    // Pending requests keep index/data until granted, but may be withdrawn.
    for (int n = 0; n < 500; n++) begin
      for (int p = 0; p < 3; p++) begin
        if (!rv[p] || obs_ready[p]) begin
          rv[p] = ($urandom_range(0, 9) < 6);
          ri[p] = 4'($urandom_range(0, 7));
          rd[p] = $urandom;
        end else if ($urandom_range(0, 9) == 0) begin
          rv[p] = 1'b0;
        end
      end
      rsvv = ($urandom_range(0, 2) == 0);
      rsvi = 4'($urandom_range(0, 7));
      fl   = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/xreg_wb_arbiter.md
Name: xreg_wb_arbiter

Overview:
- Shares the single register-file write port (wreq/windex/wdata) among three writeback sources: port 0 load return, port 1 execute result, port 2 CSR read result.
- Holds a pending-load scoreboard so the decoder can stall on registers whose load data has not returned.
- Blocks non-load writes to pending registers, preserving write-after-write order.
- Sits between the execute/LSU/CSR units and the x register file.

Parameters:
- XLEN, 32, register data width.

Ports:
- clk  in  1  core clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  3  per-port write request; bit i is port i.
- req_index  in  12  per-port destination; bits [4i+3:4i] are port i.
- req_data  in  3*XLEN  per-port write data; bits [XLEN*i+XLEN-1:XLEN*i] are port i.
- req_ready  out  3  per-port grant (combinational); transfer occurs on valid&&ready at a rising edge.
- rsv_valid  in  1  reserve request for a load destination at issue.
- rsv_index  in  4  register to reserve.
- rsv_ready  out  1  reserve accepted (combinational).
- flush  in  1  clear all busy bits (trap/redirect).
- busy  out  16  pending-load scoreboard; bit 0 is constant 0.
- wreq  out  1  register-file write strobe (registered).
- windex  out  4  register-file write index (registered).
- wdata  out  XLEN  register-file write data (registered).

Behaviour:
- Reset (async, rstn low):
  - wreq=0, windex=0, wdata=0, busy=0.
  - Round-robin pointer last=2, so port 0 has first priority after reset.
- Eligibility:
  - Port 0 is eligible whenever req_valid[0]=1.
  - Ports 1 and 2 are eligible when valid and (index==0 or busy[index]==0).
- Arbitration:
  - Round-robin, searching from last+1 mod 3 upward; exactly one eligible port is granted per cycle.
  - req_ready[i]=1 only for the granted port; all zero when nothing is eligible.
  - last updates to the granted port on each transfer and holds otherwise.
- Write port:
  - On a transfer, the next edge sets wreq = (index!=0), windex=index, wdata=data.
  - With no transfer, wreq=0 and windex/wdata hold their values.
  - Latency is one cycle. At most one write per cycle.
  - A request to index 0 completes its handshake, but no write is issued.
- Scoreboard set:
  - rsv_ready = rsv_valid && !flush && (rsv_index==0 || busy[rsv_index]==0).
  - An accepted reserve with index != 0 sets busy[index] at the edge.
  - An accepted reserve to index 0 has no effect.
- Scoreboard clear:
  - A port-0 transfer clears busy[index] at the same edge that wreq rises for it.
- Simultaneous events:
  - Port-0 clear and a reserve of the same index in one cycle: the reserve is refused (busy still 1 that cycle). Net result: cleared.
  - Port-0 clear of index A and a reserve of index B≠A in one cycle: both take effect.
  - Port-1/2 blocked on busy[A] and a port-0 write to A in the same cycle: port 1/2 becomes eligible the next cycle. The load writes first, so order is preserved.
- Flush:
  - Clears all busy bits at the edge and refuses reserves that cycle.
  - It does not cancel a transfer granted in that cycle; that write still issues.
  - Load returns for flushed reservations are still written. Discarding them is the LSU's job.
- Valid rules:
  - Valid may drop before a grant.
  - Index and data must be stable while valid is high and not yet granted.
- No state machine beyond the pointer, the busy vector and the output register.
- Reset mid-operation discards any registered write: wreq falls immediately.

Test Plan:
- Reset release with req_valid=3'b111, indices 5/6/7 → grants in order port 0, 1, 2 across three consecutive cycles. wreq high cycles 1–3 with windex 5, 6, 7 and matching data.
- Reserve x9 → busy=16'h0200 next cycle. Port 1 write to x9 gets ready=0. Port-0 write x9=32'hDEADBEEF → wreq with windex=9, busy=0. Port 1 is granted the following cycle.
- Port 2 write index 0, data 32'h1234 → req_ready[2]=1, wreq stays 0. Reserve index 0 → rsv_ready=1, busy unchanged (0).
- Reserve x3 while a port-0 write to x3 transfers in the same cycle → rsv_ready=0 and busy[3]=0 afterward. Reserve x4 with a port-0 write to x3 in the same cycle → busy=16'h0010.
- busy=16'h00F0 with flush=1 and a port-1 transfer to x2 → busy=0 next cycle, wreq=1 with windex=2. A reserve asserted during the flush is refused.
- rstn asserted low while wreq=1 → wreq, windex, wdata and busy are 0 immediately, without waiting for a clock edge. First grant after release goes to port 0.
